// File: rtl/multicycle_shifter_if.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_shifter_if
// Description : Request/result bundle between a requester and the
//               multicycle shifter.
// Revision    : 1.0 - initial release
// ============================================================================
interface multicycle_shifter_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] data_in;
  logic [31:0] shamt_in;
  logic        busy;
  logic        done;
  logic [31:0] data_out;

  // Requester side: issues operations, observes status and result
  modport master (
    output start, op, data_in, shamt_in,
    input  busy, done, data_out
  );

  // Shifter side
  modport slave (
    input  start, op, data_in, shamt_in,
    output busy, done, data_out
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_shifter.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_shifter
// Description : Iterative 32-bit shifter (SLL/SRL/SRA/ROR/ROL). Moves at most
//               BITS_PER_CYCLE positions per clock until the latched amount
//               is used up, then pulses done for one cycle.
//               BITS_PER_CYCLE must be 1, 2, 4 or 8.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_shifter #(
  parameter int BITS_PER_CYCLE = 1
) (
  input wire                  clk,
  input wire                  reset,
  multicycle_shifter_if.slave bus
);

  localparam logic [2:0] c_op_sll = 3'b000;
  localparam logic [2:0] c_op_srl = 3'b001;
  localparam logic [2:0] c_op_sra = 3'b010;
  localparam logic [2:0] c_op_ror = 3'b011;
  localparam logic [2:0] c_op_rol = 3'b100;

  localparam logic [4:0] c_step_max = 5'(BITS_PER_CYCLE);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] data_out_q, data_out_d;
  logic [2:0]  op_q, op_d;
  logic [4:0]  remaining_q, remaining_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [4:0]  w_step;
  logic [5:0]  w_step_inv;
  logic [31:0] w_shifted;
  logic [4:0]  w_n;
  logic        w_reserved;

  // Only the low five bits of the amount matter; the rest come from a wider mux
  logic unused_shamt_hi;
  assign unused_shamt_hi = ^bus.shamt_in[31:5];

  assign w_n        = bus.shamt_in[4:0];
  assign w_reserved = (bus.op > c_op_rol);

  // One iteration of the selected shift on the working value
  always_comb begin
    w_step     = (remaining_q < c_step_max) ? remaining_q : c_step_max;
    // Complementary amount for rotates; a 32-position shift yields zero
    w_step_inv = 6'd32 - {1'b0, w_step};
    case (op_q)
      c_op_sll: w_shifted = data_out_q << w_step;
      c_op_srl: w_shifted = data_out_q >> w_step;
      c_op_sra: w_shifted = $unsigned($signed(data_out_q) >>> w_step);
      c_op_ror: w_shifted = (data_out_q >> w_step) | (data_out_q << w_step_inv);
      c_op_rol: w_shifted = (data_out_q << w_step) | (data_out_q >> w_step_inv);
      default:  w_shifted = data_out_q;
    endcase
  end

  // Next-state and next-output computation
  always_comb begin
    state_d     = state_q;
    data_out_d  = data_out_q;
    op_d        = op_q;
    remaining_d = remaining_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          data_out_d  = bus.data_in;
          op_d        = bus.op;
          remaining_d = w_n;
          // Zero amount and reserved ops complete immediately as pass-through
          state_d     = ((w_n == 5'd0) || w_reserved) ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        data_out_d  = w_shifted;
        remaining_d = remaining_q - w_step;
        if (remaining_d == 5'd0) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Status outputs are registered, so derive them from the next state
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State, operand and status registers with asynchronous clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      data_out_q  <= 32'h0000_0000;
      op_q        <= c_op_sll;
      remaining_q <= 5'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_out_q  <= data_out_d;
      op_q        <= op_d;
      remaining_q <= remaining_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.data_out = data_out_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_shifter.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_shifter
// Description : Directed bench for multicycle_shifter with one instance at
//               one bit per cycle and one at four bits per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_shifter;

  logic clk;
  logic reset;

  multicycle_shifter_if b1 ();
  multicycle_shifter_if b4 ();

  multicycle_shifter #(.BITS_PER_CYCLE(1)) u_dut1 (.clk(clk), .reset(reset), .bus(b1));
  multicycle_shifter #(.BITS_PER_CYCLE(4)) u_dut4 (.clk(clk), .reset(reset), .bus(b4));

  typedef struct {
    int unsigned cyc;
    logic [31:0] data;
    string       tag;
  } exp_t;

  exp_t        q1[$];
  exp_t        q4[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc    = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle index: value k holds from the k-th rising edge to the next one
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: one bit position at a time
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] d,
                                        input logic [31:0] sh);
    logic [31:0] r;
    int n;
    r = d;
    n = int'(sh[4:0]);
    if (op > 3'd4) return d;
    for (int i = 0; i < n; i++) begin
      case (op)
        3'd0:    r = {r[30:0], 1'b0};
        3'd1:    r = {1'b0, r[31:1]};
        3'd2:    r = {r[31], r[31:1]};
        3'd3:    r = {r[0], r[31:1]};
        default: r = {r[30:0], r[31]};
      endcase
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Completion monitors: each done pulse is matched against the scoreboard
  always @(negedge clk) begin
    if (b1.done === 1'b1) begin
      checks++;
      assert (q1.size() > 0) else begin
        errors++;
        $error("FAIL dut1_unexpected_done observed=1 expected=0");
      end
      if (q1.size() > 0) begin
        exp_t e;
        e = q1.pop_front();
        chk({e.tag, "_done_cycle"}, 32'(cyc), 32'(e.cyc));
        chk({e.tag, "_data"}, b1.data_out, e.data);
      end
    end
  end

  always @(negedge clk) begin
    if (b4.done === 1'b1) begin
      checks++;
      assert (q4.size() > 0) else begin
        errors++;
        $error("FAIL dut4_unexpected_done observed=1 expected=0");
      end
      if (q4.size() > 0) begin
        exp_t e;
        e = q4.pop_front();
        chk({e.tag, "_done_cycle"}, 32'(cyc), 32'(e.cyc));
        chk({e.tag, "_data"}, b4.data_out, e.data);
      end
    end
  end

  task automatic drive(input int sel, input logic s, input logic [2:0] op,
                       input logic [31:0] d, input logic [31:0] sh);
    if (sel == 4) begin
      b4.start = s; b4.op = op; b4.data_in = d; b4.shamt_in = sh;
    end else begin
      b1.start = s; b1.op = op; b1.data_in = d; b1.shamt_in = sh;
    end
  endtask

  function automatic logic get_done(input int sel);
    return (sel == 4) ? b4.done : b1.done;
  endfunction

  function automatic logic get_busy(input int sel);
    return (sel == 4) ? b4.busy : b1.busy;
  endfunction

  function automatic logic [31:0] get_data(input int sel);
    return (sel == 4) ? b4.data_out : b1.data_out;
  endfunction

  // Called at a falling edge; start is sampled at the next rising edge.
  // Returns one cycle later with start low and junk on the operand inputs.
  task automatic start_op(input int sel, input logic [2:0] op, input logic [31:0] d,
                          input logic [31:0] sh, input string tag,
                          output logic [31:0] exp_data);
    exp_t e;
    int   n;
    int   lat;
    n        = int'(sh[4:0]);
    lat      = (n == 0 || op > 3'd4) ? 0 : (n + sel - 1) / sel;
    exp_data = model(op, d, sh);
    e.cyc    = cyc + 1 + lat;
    e.data   = exp_data;
    e.tag    = tag;
    if (sel == 4) q4.push_back(e); else q1.push_back(e);
    drive(sel, 1'b1, op, d, sh);
    @(negedge clk);
    drive(sel, 1'b0, 3'($urandom_range(0, 7)), $urandom, $urandom);
  endtask

  // Busy must stay high until done; afterwards the result must hold in IDLE
  task automatic wait_done(input int sel, input string tag, input logic [31:0] exp_data);
    int n;
    n = 0;
    while (get_done(sel) !== 1'b1 && n < 40) begin
      chk({tag, "_busy"}, 32'(get_busy(sel)), 32'd1);
      @(negedge clk);
      n++;
    end
    checks++;
    assert (get_done(sel) === 1'b1) else begin
      errors++;
      $error("FAIL %s_timeout observed=no_done expected=done", tag);
    end
    chk({tag, "_busy_in_done"}, 32'(get_busy(sel)), 32'd1);
    @(negedge clk);
    chk({tag, "_done_pulse_len"}, 32'(get_done(sel)), 32'd0);
    chk({tag, "_idle_busy"}, 32'(get_busy(sel)), 32'd0);
    chk({tag, "_hold"}, get_data(sel), exp_data);
  endtask

  initial begin
    logic [31:0] ed;
    reset = 1'b0;
    drive(1, 1'b1, 3'd0, 32'hFFFF_FFFF, 32'd3);
    drive(4, 1'b1, 3'd0, 32'hFFFF_FFFF, 32'd3);
    repeat (2) @(negedge clk);
    chk("rst_dut1_data", b1.data_out, 32'h0);
    chk("rst_dut1_busy", 32'(b1.busy), 32'd0);
    chk("rst_dut1_done", 32'(b1.done), 32'd0);
    chk("rst_dut4_data", b4.data_out, 32'h0);
    chk("rst_dut4_busy", 32'(b4.busy), 32'd0);
    drive(1, 1'b0, 3'd0, 32'h0, 32'h0);
    drive(4, 1'b0, 3'd0, 32'h0, 32'h0);
    reset = 1'b1;

    // Start issued in the first cycle after reset release
    start_op(1, 3'b010, 32'h8000_0001, 32'd4, "sra4", ed);
    chk("sra4_const", ed, 32'hF800_0000);
    wait_done(1, "sra4", ed);
    // Back-to-back, no gap after DONE
    start_op(1, 3'b100, 32'h1234_5678, 32'h0000_0028, "rol8", ed);
    chk("rol8_const", ed, 32'h3456_7812);
    wait_done(1, "rol8", ed);
    start_op(1, 3'b001, 32'hDEAD_BEEF, 32'd0, "srl0", ed);
    wait_done(1, "srl0", ed);
    start_op(1, 3'b101, 32'hDEAD_BEEF, 32'd7, "resv", ed);
    wait_done(1, "resv", ed);
    start_op(1, 3'b001, 32'hF0F0_F0F0, 32'h0000_0021, "srl_hi_bits", ed);
    wait_done(1, "srl_hi_bits", ed);

    // A second start during SHIFT must be ignored
    start_op(1, 3'b011, 32'h0000_000F, 32'd5, "ror_restart", ed);
    repeat (2) @(negedge clk);
    drive(1, 1'b1, 3'b000, 32'hAAAA_5555, 32'd17);
    @(negedge clk);
    drive(1, 1'b0, 3'b000, 32'h0, 32'h0);
    wait_done(1, "ror_restart", ed);

    start_op(4, 3'b000, 32'hFFFF_FFFF, 32'd31, "b4_sll31", ed);
    chk("b4_sll31_const", ed, 32'h8000_0000);
    wait_done(4, "b4_sll31", ed);
    start_op(4, 3'b010, 32'h8000_F000, 32'd6, "b4_sra6", ed);
    wait_done(4, "b4_sra6", ed);
    start_op(4, 3'b011, 32'h1234_5678, 32'd9, "b4_ror9", ed);
    wait_done(4, "b4_ror9", ed);
    start_op(4, 3'b100, 32'hC000_0003, 32'd13, "b4_rol13", ed);
    wait_done(4, "b4_rol13", ed);

    // Asynchronous abort in the middle of a long shift
    start_op(1, 3'b000, 32'h0000_0001, 32'd20, "abort", ed);
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("abort_data", b1.data_out, 32'h0);
    chk("abort_busy", 32'(b1.busy), 32'd0);
    chk("abort_done", 32'(b1.done), 32'd0);
    q1.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    start_op(1, 3'b010, 32'h7FFF_0000, 32'd3, "after_abort", ed);
    wait_done(1, "after_abort", ed);

    repeat (5) @(negedge clk);
    chk("dut1_queue_empty", 32'(q1.size()), 32'd0);
    chk("dut4_queue_empty", 32'(q4.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multicycle_shifter.md
MULTICYCLE_SHIFTER -- requirements
Module: multicycle_shifter

Interface
REQ-001 SHALL have parameter BITS_PER_CYCLE, default 1, giving the maximum bit positions shifted per SHIFT cycle; legal values are 1, 2, 4 and 8.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit; reset is asynchronous and active-low.
REQ-004 SHALL have port start, input, 1 bit, a request to begin a shift operation.
REQ-005 SHALL have port op, input, 3 bits: 000 SLL, 001 SRL, 010 SRA, 011 ROR, 100 ROL; 101-111 are reserved.
REQ-006 SHALL have port data_in, input, 32 bits, the operand.
REQ-007 SHALL have port shamt_in, input, 32 bits, the shift amount from the upstream shift-amount select mux; only bits [4:0] are used.
REQ-008 SHALL have port busy, output, 1 bit, high while an operation is in progress.
REQ-009 SHALL have port done, output, 1 bit, a one-cycle completion pulse.
REQ-010 SHALL have port data_out, output, 32 bits, the working/result register.

Function
REQ-011 SHALL implement a state machine with states IDLE, SHIFT and DONE.
REQ-012 SHALL, in IDLE with start=1 at an edge, latch data_in into data_out, latch op, and latch n = shamt_in[4:0] into a remaining-count register.
REQ-013 SHALL, on that same edge, go to DONE if n=0 or op is reserved; otherwise it SHALL go to SHIFT.
REQ-014 SHALL, in SHIFT, shift data_out by s = min(BITS_PER_CYCLE, remaining) per edge and decrement remaining by s.
REQ-015 SHALL go from SHIFT to DONE on the edge where remaining reaches 0.
REQ-016 SHALL, in DONE, assert done=1 for exactly one cycle and then return to IDLE on the next edge.
REQ-017 SHALL perform the operations as follows: SLL fills zeros at the LSBs; SRL fills zeros at the MSBs; SRA replicates bit 31 of the current working value; ROR and ROL are circular, with no bits lost.
REQ-018 SHALL leave data_in unchanged in data_out for reserved ops (pass-through).
REQ-019 SHALL assert done in cycle t+1+ceil(n/BITS_PER_CYCLE), where t is the cycle in which start is sampled high.
REQ-020 SHALL drive busy=1 in the SHIFT and DONE states and busy=0 in IDLE.
REQ-021 SHALL ignore start while busy=1, and SHALL NOT change the latched operands during an operation.
REQ-022 SHALL accept start=1 in the first IDLE cycle after DONE (back-to-back operation, no dead cycle beyond DONE).
REQ-023 SHALL treat shamt_in[31:5] as don't-care; for example, shamt_in=0x00000021 gives n=1.
REQ-024 SHALL hold data_out stable from DONE until the next accepted start.
REQ-025 SHALL ignore changes on data_in, op and shamt_in while busy.

Reset
REQ-026 SHALL, while reset=0 and regardless of clk, force state=IDLE, data_out=0x00000000, remaining=0, latched op=000, busy=0 and done=0.
REQ-027 SHALL abort an operation in progress when reset is asserted mid-operation, with no done pulse.
REQ-028 SHALL honour start only from the first rising edge after reset deasserts.

Verification
REQ-029 SHALL be covered by: B=1, data_in=0x80000001, op=SRA, shamt_in=4 -> done in cycle t+5, data_out=0xF8000000, busy high in cycles t+1..t+5.
REQ-030 SHALL be covered by: B=1, data_in=0x12345678, op=ROL, shamt_in=0x00000028 (n=8) -> done in cycle t+9, data_out=0x34567812.
REQ-031 SHALL be covered by: B=4, data_in=0xFFFFFFFF, op=SLL, shamt_in=31 -> done in cycle t+9, data_out=0x80000000.
REQ-032 SHALL be covered by: data_in=0xDEADBEEF, op=SRL, shamt_in=0; then op=101 -> done in cycle t+1, data_out=0xDEADBEEF, for each case.
REQ-033 SHALL be covered by: start pulsed again mid-SHIFT with different operands -> ignored, result unaffected; start in the cycle after done -> accepted.
REQ-034 SHALL be covered by: reset driven low asynchronously mid-SHIFT (between clock edges) -> outputs zero immediately, no done pulse; after release, a new operation completes correctly.
